key_pulse: RTL

Multi-channel key conditioner: synchronises asynchronous push-button inputs, debounces each with a cycle counter, and produces a registered one-cycle pulse per press, with optional auto-repeat while held. It also provides a debounced level and a press-toggled latch per channel. It sits between board buttons and the CPU control logic (single-step/run/clear keys), replacing hand-built one-shot capture.

---
 rtl/key_pulse_pkg.sv | 10 +
 rtl/key_pulse_chan.sv | 83 ++++++++
 rtl/key_pulse.sv | 29 ++
 3 files changed

// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg: shared channel state encoding and counter sizing for key_pulse
package key_pulse_pkg;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} chan_state_e;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/key_pulse_chan.sv
// key_pulse_chan: one key channel; ports clk, rst (async high), key (raw), level/pulse/toggle (registered)
module key_pulse_chan
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic pulse,
  output logic toggle
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] RD_LAST = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] RP_LAST = W'(REPEAT_PERIOD - 1);
  logic        meta_q, sync_q;
  logic        level_q, level_d, pulse_q, pulse_d, toggle_q, toggle_d;
  logic [W-1:0] dcnt_q, dcnt_d, rcnt_q, rcnt_d;
  chan_state_e state_q, state_d;
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (dcnt_q == DB_LAST) level_d = sync_q;
      else dcnt_d = dcnt_q + 1'b1;
    end
  end
  // FSM reacts to the level being committed this edge so the press pulse lands with the level.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    pulse_d  = 1'b0;
    toggle_d = toggle_q;
    case (state_q)
      IDLE: if (level_d && !level_q) begin
        pulse_d  = 1'b1;
        toggle_d = ~toggle_q;
        rcnt_d   = '0;
        state_d  = HELD;
      end
      HELD: if (!level_d) state_d = IDLE;
      else if (REPEAT_DELAY != 0 && rcnt_q == RD_LAST) begin
        pulse_d = 1'b1;
        rcnt_d  = '0;
        state_d = REPEAT;
      end else if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
      REPEAT: if (!level_d) state_d = IDLE;
      else if (rcnt_q == RP_LAST) begin
        pulse_d = 1'b1;
        rcnt_d  = '0;
      end else rcnt_d = rcnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      dcnt_q   <= '0;
      level_q  <= 1'b0;
      rcnt_q   <= '0;
      state_q  <= IDLE;
      pulse_q  <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      meta_q   <= key;
      sync_q   <= meta_q;
      dcnt_q   <= dcnt_d;
      level_q  <= level_d;
      rcnt_q   <= rcnt_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      toggle_q <= toggle_d;
    end
  end
  assign level  = level_q;
  assign pulse  = pulse_q;
  assign toggle = toggle_q;
endmodule

// File: rtl/key_pulse.sv
// key_pulse: multi-channel key conditioner; ports clk, rst (async high), key[CHANNELS] raw, level/pulse/toggle[CHANNELS]
module key_pulse #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] toggle
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    key_pulse_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .key   (key[i]),
      .level (level[i]),
      .pulse (pulse[i]),
      .toggle(toggle[i])
    );
  end
endmodule
